// File: rtl/bip_control_unit.sv
// bip_control_unit: fetch/decode/exec sequencer driving BIP accumulator, ALU and data-RAM strobes
// Ports: clk, reset (async, active-high), start (run from PC=0 out of IDLE/HALT);
//   prog_addr/prog_data: PROGRAM_MEM address (=PC) and 1-cycle-latency read data;
//   operand: IR[10:0]; sel_a/sel_b/wr_acc/alu_op/wr_ram/rd_ram: datapath controls, EXEC only;
//   busy (FETCH/DECODE/EXEC), halted (HALT), cycle_count (saturating busy-clock count).
module bip_control_unit #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int OP_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [ADDR_W-1:0] operand,
    output logic [1:0]        sel_a,
    output logic              sel_b,
    output logic              wr_acc,
    output logic              alu_op,
    output logic              wr_ram,
    output logic              rd_ram,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
    localparam logic [OP_W-1:0] HLT = 0, STO = 1, LD = 2, LDI = 3, ADD = 4, ADDI = 5, SUB = 6, SUBI = 7;
    state_t state, state_n;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [OP_W-1:0] op;
    assign op = ir[DATA_W-1 -: OP_W];
    assign prog_addr = pc;
    assign operand = ir[ADDR_W-1:0];
    assign busy = state == FETCH || state == DECODE || state == EXEC;
    assign halted = state == HALT;
    always_comb begin
        state_n = state;
        sel_a = 2'b00;
        sel_b = 1'b0;
        wr_acc = 1'b0;
        alu_op = 1'b0;
        wr_ram = 1'b0;
        rd_ram = 1'b0;
        case (state)
            IDLE, HALT: state_n = start ? FETCH : state;
            FETCH: state_n = DECODE;
            DECODE: state_n = EXEC;
            EXEC: begin
                state_n = op == HLT ? HALT : FETCH;
                case (op)
                    STO: wr_ram = 1'b1;
                    LD: begin
                        rd_ram = 1'b1;
                        wr_acc = 1'b1;
                    end
                    LDI: begin
                        sel_a = 2'b01;
                        wr_acc = 1'b1;
                    end
                    ADD, ADDI, SUB, SUBI: begin
                        rd_ram = op == ADD || op == SUB;
                        sel_b = op == ADDI || op == SUBI;
                        alu_op = op == SUB || op == SUBI;
                        sel_a = 2'b10;
                        wr_acc = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            ir <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_n;
            if (state == DECODE) ir <= prog_data;
            if (state == EXEC && op != HLT) pc <= pc + ADDR_W'(1);
            else if (halted && start) pc <= '0;
            if (halted && start) cycle_count <= '0;
            else if (busy && !(&cycle_count)) cycle_count <= cycle_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: table-driven and randomized checks of bip_control_unit against an instruction-level model
module tb_bip_control_unit;
    logic clk = 0, reset = 1, start = 0;
    logic [10:0] prog_addr, operand;
    logic [15:0] prog_data;
    logic [1:0] sel_a;
    logic sel_b, wr_acc, alu_op, wr_ram, rd_ram, busy, halted;
    logic [15:0] cycle_count;
    logic [15:0] rom [2048];
    logic [6:0] ctrl;
    int checks = 0, errors = 0;
    typedef struct {
        logic [4:0] op;
        logic [6:0] ctrl;
    } vec_t;
    vec_t tbl [10];
    always #5 clk = ~clk;
    always @(posedge clk) prog_data <= rom[prog_addr];
    assign ctrl = {sel_a, sel_b, wr_acc, alu_op, wr_ram, rd_ram};
    bip_control_unit dut (
        .clk(clk), .reset(reset), .start(start), .prog_addr(prog_addr), .prog_data(prog_data),
        .operand(operand), .sel_a(sel_a), .sel_b(sel_b), .wr_acc(wr_acc), .alu_op(alu_op),
        .wr_ram(wr_ram), .rd_ram(rd_ram), .busy(busy), .halted(halted), .cycle_count(cycle_count)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [6:0] exp_ctrl(input logic [4:0] op);
        exp_ctrl = '0;
        foreach (tbl[i]) if (tbl[i].op == op) exp_ctrl = tbl[i].ctrl;
    endfunction
    // Instruction k executes from address k and its controls show on the 3rd of its 3 clocks;
    // the HLT at index n leaves the unit halted with 3*(n+1) busy clocks counted.
    task automatic run(input int n, input int glitch);
        int k, ph;
        logic [15:0] ins;
        @(negedge clk) start = 1;
        for (int c = 1; c <= 3 * (n + 1); c++) begin
            @(negedge clk);
            start = (c == glitch);
            k = (c - 1) / 3;
            ph = (c - 1) % 3;
            ins = rom[k % 2048];
            chk("busy", busy, 1);
            chk("halted", halted, 0);
            chk("prog_addr", prog_addr, k % 2048);
            chk("cycle_count", cycle_count, c - 1);
            chk("ctrl", ctrl, ph == 2 ? exp_ctrl(ins[15:11]) : 7'd0);
            if (ph == 2) chk("operand", operand, ins[10:0]);
        end
        @(negedge clk);
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_prog_addr", prog_addr, n);
        chk("halt_cycle_count", cycle_count, 3 * (n + 1));
        chk("halt_ctrl", ctrl, 0);
    endtask
    initial begin
        int n;
        tbl[0] = '{5'd0, 7'b00_0_0_0_0_0};
        tbl[1] = '{5'd1, 7'b00_0_0_0_1_0};
        tbl[2] = '{5'd2, 7'b00_0_1_0_0_1};
        tbl[3] = '{5'd3, 7'b01_0_1_0_0_0};
        tbl[4] = '{5'd4, 7'b10_0_1_0_0_1};
        tbl[5] = '{5'd5, 7'b10_1_1_0_0_0};
        tbl[6] = '{5'd6, 7'b10_0_1_1_0_1};
        tbl[7] = '{5'd7, 7'b10_1_1_1_0_0};
        tbl[8] = '{5'd8, 7'b00_0_0_0_0_0};
        tbl[9] = '{5'd31, 7'b00_0_0_0_0_0};
        foreach (rom[i]) rom[i] = 16'h0000;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_prog_addr", prog_addr, 0);
        chk("rst_operand", operand, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_cycle_count", cycle_count, 0);
        @(negedge clk) reset = 0;
        rom[0] = {5'd3, 11'd5};
        rom[1] = {5'd5, 11'd3};
        rom[2] = {5'd1, 11'd10};
        rom[3] = 16'h0000;
        run(3, 0);
        for (int i = 0; i < 9; i++) rom[i] = {tbl[i + 1].op, 11'($urandom_range(0, 2047))};
        rom[9] = {5'd0, 11'($urandom_range(0, 2047))};
        run(9, 2);
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) rom[i] = {5'($urandom_range(1, 31)), 11'($urandom_range(0, 2047))};
            rom[n] = {5'd0, 11'($urandom_range(0, 2047))};
            run(n, (t % 2 == 0) ? 2 + 3 * (n / 2) : 0);
        end
        rom[0] = {5'd4, 11'd9};
        rom[1] = 16'h0000;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        repeat (2) @(negedge clk);
        chk("add_rd_ram", rd_ram, 1);
        chk("add_sel_a", sel_a, 2'b10);
        #1 reset = 1;
        #1;
        chk("arst_ctrl", ctrl, 0);
        chk("arst_busy", busy, 0);
        chk("arst_prog_addr", prog_addr, 0);
        chk("arst_operand", operand, 0);
        chk("arst_cycle_count", cycle_count, 0);
        @(negedge clk) reset = 0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_ctrl", ctrl, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_halted", halted, 0);
        end
        foreach (rom[i]) rom[i] = {5'd8, 11'd0};
        @(negedge clk) start = 1;
        for (int c = 1; c <= 3 * 2048 + 1; c++) begin
            @(negedge clk);
            start = 0;
            if (c == 3 * 2047 + 1) chk("wrap_pc_top", prog_addr, 2047);
            if (c == 3 * 2048 + 1) begin
                chk("wrap_pc_zero", prog_addr, 0);
                chk("wrap_cycle_count", cycle_count, 3 * 2048);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
